pool2d_engine: RTL and testbench

//  Parametrised 2-D pooling engine: on a start pulse, walks an IMG_W x IMG_H

---
 rtl/pool2d_engine.sv | 209 ++++++++++++++++++++
 tb/tb_pool2d_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pool2d_engine.sv
// pool2d_engine: sliding-window max/average pooling over a feature map in BRAM.
// Each window is read K*K pixels in row-major order. The engine waits RD_LATENCY
// cycles for the read data to drain, then writes one result to the output BRAM.
module pool2d_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 4,
  parameter int IMG_H      = 4,
  parameter int KERNEL_DIM = 2,
  parameter int STRIDE     = 2,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int OUT_W = (IMG_W - KERNEL_DIM) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - KERNEL_DIM) / STRIDE + 1;
  localparam int KK    = KERNEL_DIM * KERNEL_DIM;
  localparam int ACC_W = DATA_WIDTH + $clog2(KK);
  localparam int CW    = $clog2(IMG_W + IMG_H + KERNEL_DIM + RD_LATENCY) + 1;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   ox, oy, kx, ky, dcnt;
  logic [CW-1:0]   ox_n, oy_n, kx_n, ky_n, dcnt_n;
  logic            mode_r, mode_n;
  logic            busy_n, done_n, rd_en_n, wr_en_n;
  logic [ADDR_WIDTH-1:0] rd_addr_n, wr_addr_n;
  logic [DATA_WIDTH-1:0] wr_data_n;

  logic [ACC_W-1:0]      acc, acc_nxt;
  logic [DATA_WIDTH-1:0] result;
  logic [RD_LATENCY:1]   vld_pipe, fst_pipe;
  logic                  fst0;

  // Input-map address of pixel (kx,ky) inside output window (ox,oy).
  function automatic logic [ADDR_WIDTH-1:0] rd_at(input logic [CW-1:0] x, y, i, j);
    return ADDR_WIDTH'((32'(y) * STRIDE + 32'(j)) * IMG_W + 32'(x) * STRIDE + 32'(i));
  endfunction

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ox      <= '0;
      oy      <= '0;
      kx      <= '0;
      ky      <= '0;
      dcnt    <= '0;
      mode_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      ox      <= ox_n;
      oy      <= oy_n;
      kx      <= kx_n;
      ky      <= ky_n;
      dcnt    <= dcnt_n;
      mode_r  <= mode_n;
      busy    <= busy_n;
      done    <= done_n;
      rd_en   <= rd_en_n;
      rd_addr <= rd_addr_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  // Next-state and next-output logic; outputs are registered one cycle ahead.
  always_comb begin
    state_n   = state;
    ox_n      = ox;
    oy_n      = oy;
    kx_n      = kx;
    ky_n      = ky;
    dcnt_n    = dcnt;
    mode_n    = mode_r;
    busy_n    = busy;
    done_n    = 1'b0;
    rd_en_n   = 1'b0;
    rd_addr_n = rd_addr;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = READ;
          mode_n    = mode;
          ox_n      = '0;
          oy_n      = '0;
          kx_n      = '0;
          ky_n      = '0;
          busy_n    = 1'b1;
          rd_en_n   = 1'b1;
          rd_addr_n = rd_at('0, '0, '0, '0);
        end
      end
      READ: begin
        if (kx == CW'(KERNEL_DIM - 1) && ky == CW'(KERNEL_DIM - 1)) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          if (kx == CW'(KERNEL_DIM - 1)) begin
            kx_n = '0;
            ky_n = ky + 1'b1;
          end else begin
            kx_n = kx + 1'b1;
          end
          rd_en_n   = 1'b1;
          rd_addr_n = rd_at(ox, oy, kx_n, ky_n);
        end
      end
      DRAIN: begin
        // The last sample lands in the accumulator on this same edge, so the
        // written value is taken from the accumulator's next value.
        if (dcnt == CW'(RD_LATENCY - 1)) begin
          state_n   = WRITE;
          wr_en_n   = 1'b1;
          wr_data_n = result;
          wr_addr_n = ADDR_WIDTH'(32'(oy) * OUT_W + 32'(ox));
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      WRITE: begin
        if (ox == CW'(OUT_W - 1) && oy == CW'(OUT_H - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          ox_n    = '0;
          oy_n    = '0;
        end else begin
          if (ox == CW'(OUT_W - 1)) begin
            ox_n = '0;
            oy_n = oy + 1'b1;
          end else begin
            ox_n = ox + 1'b1;
          end
          kx_n      = '0;
          ky_n      = '0;
          state_n   = READ;
          rd_en_n   = 1'b1;
          rd_addr_n = rd_at(ox_n, oy_n, '0, '0);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The first read of each window is tagged so its sample reloads the accumulator.
  assign fst0 = rd_en && (kx == '0) && (ky == '0);

  // Read-valid and first-sample tags delayed by the BRAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      fst_pipe <= '0;
    end else begin
      for (int i = RD_LATENCY; i >= 2; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        fst_pipe[i] <= fst_pipe[i-1];
      end
      vld_pipe[1] <= rd_en;
      fst_pipe[1] <= fst0;
    end
  end

  // Accumulator update: load on first sample, otherwise max or sum.
  always_comb begin
    acc_nxt = acc;
    if (vld_pipe[RD_LATENCY]) begin
      if (fst_pipe[RD_LATENCY])
        acc_nxt = ACC_W'(rd_data);
      else if (mode_r)
        acc_nxt = acc + ACC_W'(rd_data);
      else if (rd_data > acc[DATA_WIDTH-1:0])
        acc_nxt = ACC_W'(rd_data);
    end
    result = mode_r ? DATA_WIDTH'(acc_nxt / ACC_W'(KK)) : acc_nxt[DATA_WIDTH-1:0];
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= acc_nxt;
  end

endmodule

// File: tb/tb_pool2d_engine.sv
// Directed bench: three engines (default config, K=3/S=1, read latency 3) share the
// stimulus and a common input map. Writes and done pulses are logged with cycle stamps.
module tb_pool2d_engine;

  logic clk = 1'b0;
  logic rst, start, mode;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [16];
  logic [2:0]       busy_v, done_v, rd_en_v, wr_en_v;
  logic [2:0][3:0]  rd_addr_v, wr_addr_v;
  logic [2:0][7:0]  rd_data_v, wr_data_v;
  logic [7:0]       q0, q1;
  logic [7:0]       s2 [3];

  // BRAM models: latency 1 for instances 0/1, latency 3 for instance 2.
  always @(posedge clk) begin
    if (rd_en_v[0]) q0 <= mem[rd_addr_v[0]];
    if (rd_en_v[1]) q1 <= mem[rd_addr_v[1]];
    s2[0] <= mem[rd_addr_v[2]];
    s2[1] <= s2[0];
    s2[2] <= s2[1];
  end
  assign rd_data_v[0] = q0;
  assign rd_data_v[1] = q1;
  assign rd_data_v[2] = s2[2];

  pool2d_engine dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy_v[0]), .done(done_v[0]), .rd_en(rd_en_v[0]), .rd_addr(rd_addr_v[0]),
    .rd_data(rd_data_v[0]), .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]));

  pool2d_engine #(.KERNEL_DIM(3), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy_v[1]), .done(done_v[1]), .rd_en(rd_en_v[1]), .rd_addr(rd_addr_v[1]),
    .rd_data(rd_data_v[1]), .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]));

  pool2d_engine #(.RD_LATENCY(3)) dut2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy_v[2]), .done(done_v[2]), .rd_en(rd_en_v[2]), .rd_addr(rd_addr_v[2]),
    .rd_data(rd_data_v[2]), .wr_en(wr_en_v[2]), .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2]));

  // Event log, sampled on the falling edge.
  int n_wr [3];
  int w_t  [3][64];
  int w_a  [3][64];
  int w_d  [3][64];
  int n_dn [3];
  int t_dn [3][8];
  int n_rd1;
  int r1   [64];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr_en_v[i] && n_wr[i] < 64) begin
        w_t[i][n_wr[i]] = cyc;
        w_a[i][n_wr[i]] = int'(wr_addr_v[i]);
        w_d[i][n_wr[i]] = int'(wr_data_v[i]);
        n_wr[i]++;
      end
      if (done_v[i] && n_dn[i] < 8) begin
        t_dn[i][n_dn[i]] = cyc;
        n_dn[i]++;
      end
    end
    if (rd_en_v[1] && n_rd1 < 64) begin
      r1[n_rd1] = int'(rd_addr_v[1]);
      n_rd1++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int bw [3];
  int bd [3];
  int br1;
  int t0;

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      bw[i] = n_wr[i];
      bd[i] = n_dn[i];
    end
    br1 = n_rd1;
  endtask

  task automatic pulse_start(input logic m, output int ts);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    ts    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_all(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (n_dn[0] > bd[0] && n_dn[1] > bd[1] && n_dn[2] > bd[2]) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, " completion"}, 32'(ok), 32'd1);
  endtask

  // Four writes at addresses 0..3, window period per, done one cycle after the last.
  task automatic chk_inst(input int i, input int per, input int d0, d1, d2, d3, input string tag);
    int ed [4];
    ed = '{d0, d1, d2, d3};
    chk($sformatf("%s u%0d write count", tag, i), 32'(n_wr[i] - bw[i]), 32'd4);
    chk($sformatf("%s u%0d done count", tag, i), 32'(n_dn[i] - bd[i]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s u%0d w%0d addr", tag, i, k), 32'(w_a[i][bw[i]+k]), 32'(k));
      chk($sformatf("%s u%0d w%0d data", tag, i, k), 32'(w_d[i][bw[i]+k]), 32'(ed[k]));
      chk($sformatf("%s u%0d w%0d time", tag, i, k), 32'(w_t[i][bw[i]+k] - t0), 32'(per * (k + 1)));
    end
    chk($sformatf("%s u%0d done time", tag, i), 32'(t_dn[i][bd[i]] - t0), 32'(4 * per + 1));
  endtask

  initial begin
    int ro [9];
    ro = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",    32'(busy_v),    32'd0);
    chk("reset done",    32'(done_v),    32'd0);
    chk("reset rd_en",   32'(rd_en_v),   32'd0);
    chk("reset wr_en",   32'(wr_en_v),   32'd0);
    chk("reset rd_addr", 32'(rd_addr_v), 32'd0);
    chk("reset wr_addr", 32'(wr_addr_v), 32'd0);
    chk("reset wr_data", 32'(wr_data_v), 32'd0);
    rst = 1'b0;

    // Ramp, max mode.
    snap();
    pulse_start(1'b0, t0);
    chk("max busy", 32'(busy_v), 32'b111);
    wait_all("max");
    repeat (5) @(posedge clk);
    chk_inst(0, 6,  5,  7, 13, 15, "max");
    chk_inst(1, 11, 10, 11, 14, 15, "max");
    chk_inst(2, 8,  5,  7, 13, 15, "max");
    for (int j = 0; j < 9; j++)
      chk($sformatf("k3 read order %0d", j), 32'(r1[br1+j]), 32'(ro[j]));

    // Ramp, average mode.
    snap();
    pulse_start(1'b1, t0);
    wait_all("avg");
    repeat (5) @(posedge clk);
    chk_inst(0, 6,  2, 4, 10, 12, "avg");
    chk_inst(1, 11, 5, 6,  9, 10, "avg");
    chk_inst(2, 8,  2, 4, 10, 12, "avg");

    // All 0xFF, average mode: no overflow in the sum.
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    snap();
    pulse_start(1'b1, t0);
    wait_all("ff");
    repeat (5) @(posedge clk);
    chk_inst(0, 6,  255, 255, 255, 255, "ff");
    chk_inst(1, 11, 255, 255, 255, 255, "ff");
    chk_inst(2, 8,  255, 255, 255, 255, "ff");
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);

    // start re-pulsed (with mode=1) while busy must be ignored.
    snap();
    pulse_start(1'b0, t0);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; mode = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; mode = 1'b0;
    wait_all("repulse");
    repeat (60) @(posedge clk);
    chk_inst(0, 6,  5,  7, 13, 15, "repulse");
    chk_inst(1, 11, 10, 11, 14, 15, "repulse");
    chk_inst(2, 8,  5,  7, 13, 15, "repulse");

    // Reset in the middle of the first window.
    snap();
    pulse_start(1'b0, t0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy",  32'(busy_v),  32'd0);
    chk("midrst wr_en", 32'(wr_en_v), 32'd0);
    chk("midrst rd_en", 32'(rd_en_v), 32'd0);
    repeat (60) @(posedge clk);
    chk("midrst no writes", 32'(n_wr[0] - bw[0]), 32'd0);
    chk("midrst no done",   32'(n_dn[0] - bd[0]), 32'd0);
    snap();
    pulse_start(1'b0, t0);
    wait_all("after rst");
    repeat (5) @(posedge clk);
    chk_inst(0, 6, 5, 7, 13, 15, "after rst");
    chk_inst(2, 8, 5, 7, 13, 15, "after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
